// File: rtl/tlb_pkg.sv
// ==================================================================
// tlb_pkg: op/exception/grant/state encodings for tlb_access_arbiter
// Rev 1.0
// ==================================================================
`default_nettype none

package tlb_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } cp0_op_e;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_REFILL  = 2'd1,
    EXC_INVALID = 2'd2,
    EXC_MOD     = 2'd3
  } exc_e;

  // Values double as bit positions in the {cp0, data, inst} request vector.
  typedef enum logic [1:0] {
    GNT_INST = 2'd0,
    GNT_DATA = 2'd1,
    GNT_CP0  = 2'd2
  } gnt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] KSEG01_MASK = 32'h1FFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/tlb_random_ctr.sv
// ==================================================================
// tlb_random_ctr: CP0 Random register, free-running down to Wired
// Rev 1.0
// ==================================================================
`default_nettype none

module tlb_random_ctr #(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRIES - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random <= TOP;
    end else if (wired_we || (wired >= TOP) || (random == wired)) begin
      random <= TOP;
    end else begin
      random <= random - IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlb_access_arbiter.sv
// ==================================================================
// tlb_access_arbiter: 3-cycle arbitration of the shared TLB port
// Rev 1.0
// ==================================================================
`default_nettype none

module tlb_access_arbiter
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic [31:0]      inst_vaddr,
  output logic             inst_ok,
  output logic [31:0]      inst_paddr,
  output logic [1:0]       inst_exc,
  input  logic             data_req,
  input  logic [31:0]      data_vaddr,
  input  logic             data_store,
  output logic             data_ok,
  output logic [31:0]      data_paddr,
  output logic [1:0]       data_exc,
  input  logic             cp0_req,
  input  logic [1:0]       cp0_op,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [18:0]      cp0_vpn2,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             cp0_wired_we,
  output logic             cp0_ok,
  output logic [31:0]      cp0_probe,
  output logic [IDX_W-1:0] cp0_random,
  output logic [31:0]      tlb_vaddr,
  input  logic             tlb_hit,
  input  logic [IDX_W-1:0] tlb_hit_idx,
  input  logic [19:0]      tlb_pfn,
  input  logic             tlb_v,
  input  logic             tlb_d,
  output logic [IDX_W-1:0] tlb_ridx,
  output logic             tlb_wen,
  output logic [IDX_W-1:0] tlb_widx
);

  state_e      state, state_nxt;
  gnt_e        gnt, gnt_sel;
  cp0_op_e     op_q;
  logic [31:0] vaddr_q;
  logic        store_q;
  logic [2:0]  req_vec, blocked, eligible, done_mask;
  logic [31:0] paddr_c, probe_c;
  exc_e        exc_c;

  assign req_vec   = {cp0_req, data_req, inst_req};
  assign eligible  = req_vec & ~blocked;
  assign done_mask = (state == ST_DONE) ? (3'b001 << gnt) : 3'b000;

  always_comb begin
    gnt_sel = GNT_INST;
    if (eligible[2])      gnt_sel = GNT_CP0;
    else if (eligible[1]) gnt_sel = GNT_DATA;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inst_ok   = 1'b0;
    data_ok   = 1'b0;
    cp0_ok    = 1'b0;
    tlb_vaddr = '0;
    tlb_wen   = 1'b0;
    tlb_widx  = '0;
    tlb_ridx  = '0;
    case (state)
      ST_IDLE: if (|eligible) state_nxt = ST_BUSY;
      ST_BUSY: begin
        state_nxt = ST_DONE;
        tlb_vaddr = vaddr_q;
        if (gnt == GNT_CP0) begin
          case (op_q)
            OP_TLBR:  tlb_ridx = cp0_index;
            OP_TLBWI: begin
              tlb_wen  = 1'b1;
              tlb_widx = cp0_index;
            end
            OP_TLBWR: begin
              tlb_wen  = 1'b1;
              tlb_widx = cp0_random;
            end
            default: ;
          endcase
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        inst_ok   = (gnt == GNT_INST);
        data_ok   = (gnt == GNT_DATA);
        cp0_ok    = (gnt == GNT_CP0);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // TLBP looks up EntryHi through the same address path as translations.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt     <= GNT_INST;
      vaddr_q <= '0;
      store_q <= 1'b0;
      op_q    <= OP_TLBP;
    end else if ((state == ST_IDLE) && (|eligible)) begin
      gnt  <= gnt_sel;
      op_q <= cp0_op_e'(cp0_op);
      case (gnt_sel)
        GNT_CP0: begin
          vaddr_q <= {cp0_vpn2, 13'b0};
          store_q <= 1'b0;
        end
        GNT_DATA: begin
          vaddr_q <= data_vaddr;
          store_q <= data_store;
        end
        default: begin
          vaddr_q <= inst_vaddr;
          store_q <= 1'b0;
        end
      endcase
    end
  end

  // A requester that just got its ok must drop req before it can win again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) blocked <= '0;
    else         blocked <= (blocked & req_vec) | done_mask;
  end

  always_comb begin
    exc_c   = EXC_NONE;
    paddr_c = {tlb_pfn, vaddr_q[11:0]};
    if (vaddr_q[31:30] == 2'b10) begin
      paddr_c = vaddr_q & KSEG01_MASK;
    end else if (!tlb_hit) begin
      exc_c = EXC_REFILL;
    end else if (!tlb_v) begin
      exc_c = EXC_INVALID;
    end else if (store_q && !tlb_d) begin
      exc_c = EXC_MOD;
    end
    if (exc_c != EXC_NONE) paddr_c = '0;
  end

  assign probe_c = {~tlb_hit, {(31 - IDX_W){1'b0}}, (tlb_hit ? tlb_hit_idx : {IDX_W{1'b0}})};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_paddr <= '0;
      inst_exc   <= '0;
      data_paddr <= '0;
      data_exc   <= '0;
      cp0_probe  <= '0;
    end else if (state == ST_BUSY) begin
      case (gnt)
        GNT_INST: begin
          inst_paddr <= paddr_c;
          inst_exc   <= exc_c;
        end
        GNT_DATA: begin
          data_paddr <= paddr_c;
          data_exc   <= exc_c;
        end
        GNT_CP0: if (op_q == OP_TLBP) cp0_probe <= probe_c;
        default: ;
      endcase
    end
  end

  tlb_random_ctr #(
    .TLB_ENTRIES (TLB_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_random (
    .clk      (clk),
    .resetn   (resetn),
    .wired    (cp0_wired),
    .wired_we (cp0_wired_we),
    .random   (cp0_random)
  );

endmodule

`default_nettype wire

// File: tb/tb_tlb_access_arbiter.sv
// ==================================================================
// tb_tlb_access_arbiter: scoreboard bench with a small TLB model
// Rev 1.0
// ==================================================================
`default_nettype none

module tb_tlb_access_arbiter;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0, data_store = 1'b0, cp0_req = 1'b0;
  logic [31:0] inst_vaddr = '0, data_vaddr = '0;
  logic [1:0]  cp0_op = '0;
  logic [4:0]  cp0_index = '0, cp0_wired = '0;
  logic [18:0] cp0_vpn2 = '0;
  logic        cp0_wired_we = 1'b0;
  logic        inst_ok, data_ok, cp0_ok, tlb_wen;
  logic [31:0] inst_paddr, data_paddr, cp0_probe, tlb_vaddr;
  logic [1:0]  inst_exc, data_exc;
  logic [4:0]  cp0_random, tlb_ridx, tlb_widx, tlb_hit_idx;
  logic        tlb_hit, tlb_v, tlb_d;
  logic [19:0] tlb_pfn;

  tlb_access_arbiter #(.TLB_ENTRIES(32), .IDX_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_ok(inst_ok),
    .inst_paddr(inst_paddr), .inst_exc(inst_exc),
    .data_req(data_req), .data_vaddr(data_vaddr), .data_store(data_store),
    .data_ok(data_ok), .data_paddr(data_paddr), .data_exc(data_exc),
    .cp0_req(cp0_req), .cp0_op(cp0_op), .cp0_index(cp0_index), .cp0_vpn2(cp0_vpn2),
    .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we), .cp0_ok(cp0_ok),
    .cp0_probe(cp0_probe), .cp0_random(cp0_random),
    .tlb_vaddr(tlb_vaddr), .tlb_hit(tlb_hit), .tlb_hit_idx(tlb_hit_idx),
    .tlb_pfn(tlb_pfn), .tlb_v(tlb_v), .tlb_d(tlb_d),
    .tlb_ridx(tlb_ridx), .tlb_wen(tlb_wen), .tlb_widx(tlb_widx)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // TLB contents: index i holds VPN2 e_vpn2[i]; even/odd halves selected by vaddr[12].
  logic [18:0] e_vpn2 [4] = '{19'h00001, 19'h00002, 19'h00003, 19'h40000};
  logic [19:0] e_pfn0 [4] = '{20'h01111, 20'h03333, 20'h05555, 20'h07777};
  logic [19:0] e_pfn1 [4] = '{20'h02222, 20'h04444, 20'h06666, 20'h07777};
  logic [3:0]  e_v0 = 4'b1011, e_d0 = 4'b1010, e_v1 = 4'b1111, e_d1 = 4'b1110;

  function automatic int find(input logic [18:0] vpn2);
    for (int i = 0; i < 4; i++) if (e_vpn2[i] == vpn2) return i;
    return -1;
  endfunction

  always_comb begin
    int h;
    h           = find(tlb_vaddr[31:13]);
    tlb_hit     = 1'b0;
    tlb_hit_idx = '0;
    tlb_pfn     = '0;
    tlb_v       = 1'b0;
    tlb_d       = 1'b0;
    if (h >= 0) begin
      tlb_hit     = 1'b1;
      tlb_hit_idx = 5'(h);
      tlb_pfn     = tlb_vaddr[12] ? e_pfn1[h] : e_pfn0[h];
      tlb_v       = tlb_vaddr[12] ? e_v1[h]   : e_v0[h];
      tlb_d       = tlb_vaddr[12] ? e_d1[h]   : e_d0[h];
    end
  end

  function automatic void ref_xlate(input logic [31:0] va, input logic st,
                                    output logic [31:0] pa, output logic [1:0] ex);
    int h;
    logic [19:0] pfn;
    logic v, d;
    pa = '0;
    ex = 2'd0;
    if (va[31:30] == 2'b10) begin
      pa = {3'b000, va[28:0]};
      return;
    end
    h = find(va[31:13]);
    if (h < 0) begin
      ex = 2'd1;
      return;
    end
    pfn = va[12] ? e_pfn1[h] : e_pfn0[h];
    v   = va[12] ? e_v1[h]   : e_v0[h];
    d   = va[12] ? e_d1[h]   : e_d0[h];
    if (!v)            ex = 2'd2;
    else if (st && !d) ex = 2'd3;
    else               pa = {pfn, va[11:0]};
  endfunction

  typedef struct {
    int          src;   // 0 inst, 1 data, 2 cp0
    logic [31:0] val;
    logic [31:0] mask;
    logic [1:0]  exc;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0;
  logic [31:0] last_probe = '0, last_mask = '1;
  int t0 = 0;
  bit rnd_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // After Wired=4 is written, Random shows 31 at t0 and walks 31..4 with period 28.
  function automatic int exp_rand(input int c);
    return 31 - ((c - t0) % 28);
  endfunction

  task automatic pop_cmp(input int src, input logic [31:0] val, input logic [1:0] exc);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ok: requester %0d got ok, required no ok (cycle %0d)", src, cyc);
    end else begin
      e = sb.pop_front();
      check("ok_src", src, e.src);
      check("ok_cycle", cyc, e.cyc);
      check("result", val & e.mask, e.val & e.mask);
      check("exc", {30'b0, exc}, {30'b0, e.exc});
    end
  endtask

  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (resetn) begin
        n = int'(inst_ok) + int'(data_ok) + int'(cp0_ok);
        if (n > 0) check("one_ok_per_cycle", n, 1);
        if (cp0_ok)  pop_cmp(2, cp0_probe, 2'b00);
        if (data_ok) pop_cmp(1, data_paddr, data_exc);
        if (inst_ok) pop_cmp(0, inst_paddr, inst_exc);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_phase) check("random_seq", cp0_random, exp_rand(cyc));
    end
  end

  // Called just after a clock edge with the arbiter idle.
  task automatic run_one(input int kind, input logic [31:0] va, input logic st,
                         input logic [1:0] op, input logic [4:0] idx);
    exp_t e;
    logic [31:0] pa;
    logic [1:0] ex;
    int c, h;
    bit seen;
    c      = cyc;
    e.src  = kind;
    e.cyc  = c + 2;
    e.exc  = 2'd0;
    e.mask = '1;
    e.val  = '0;
    case (kind)
      0: begin
        ref_xlate(va, 1'b0, pa, ex);
        e.val = pa; e.exc = ex;
        inst_vaddr = va; inst_req = 1'b1;
      end
      1: begin
        ref_xlate(va, st, pa, ex);
        e.val = pa; e.exc = ex;
        data_vaddr = va; data_store = st; data_req = 1'b1;
      end
      default: begin
        cp0_op = op; cp0_index = idx; cp0_vpn2 = va[31:13]; cp0_req = 1'b1;
        if (op == 2'd0) begin
          h = find(va[31:13]);
          if (h >= 0) begin
            last_probe = 32'(h); last_mask = '1;
          end else begin
            last_probe = 32'h8000_0000; last_mask = 32'h8000_0000;
          end
        end
        e.val = last_probe; e.mask = last_mask;
      end
    endcase
    sb.push_back(e);
    @(negedge clk);
    check("wen_idle", {31'b0, tlb_wen}, 0);
    @(negedge clk);
    if (kind < 2) check("lookup_vaddr", tlb_vaddr, va);
    else begin
      case (op)
        2'd0: check("probe_vaddr", tlb_vaddr, {va[31:13], 13'b0});
        2'd1: check("tlbr_ridx", {27'b0, tlb_ridx}, {27'b0, idx});
        2'd2: begin
          check("tlbwi_wen", {31'b0, tlb_wen}, 1);
          check("tlbwi_widx", {27'b0, tlb_widx}, {27'b0, idx});
        end
        default: begin
          check("tlbwr_wen", {31'b0, tlb_wen}, 1);
          check("tlbwr_widx", {27'b0, tlb_widx}, exp_rand(cyc));
          check("tlbwr_widx_range", {31'b0, (tlb_widx >= 5'd4)}, 1);
        end
      endcase
    end
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      seen = (kind == 0) ? inst_ok : (kind == 1) ? data_ok : cp0_ok;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ok_timeout: no ok seen, required ok at cycle %0d", c + 2);
      sb.delete();
    end else if (kind == 2) begin
      check("wen_done", {31'b0, tlb_wen}, 0);
    end
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0; cp0_req = 1'b0; data_store = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_va();
    case ($urandom_range(0, 5))
      0: return {19'h00001, 13'($urandom)};
      1: return {19'h00002, 13'($urandom)};
      2: return {19'h00003, 13'($urandom)};
      3: return {19'h40000, 13'($urandom)};
      4: return {2'b10, 30'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    bit d_cp, d_d, d_i;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ok", {29'b0, inst_ok, data_ok, cp0_ok}, 0);
    check("rst_wen", {31'b0, tlb_wen}, 0);
    check("rst_inst_paddr", inst_paddr, 0);
    check("rst_data_paddr", data_paddr, 0);
    check("rst_exc", {28'b0, inst_exc, data_exc}, 0);
    check("rst_probe", cp0_probe, 0);
    check("rst_tlb_vaddr", tlb_vaddr, 0);
    check("rst_random", {27'b0, cp0_random}, 31);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_one(1, 32'h0000_2004, 1'b0, 2'd0, 5'd0);
    run_one(1, 32'h0000_2004, 1'b1, 2'd0, 5'd0);
    run_one(1, 32'h0000_5008, 1'b1, 2'd0, 5'd0);
    run_one(1, 32'h0000_6010, 1'b0, 2'd0, 5'd0);
    run_one(0, 32'hF000_0000, 1'b0, 2'd0, 5'd0);
    run_one(0, 32'hA000_1234, 1'b0, 2'd0, 5'd0);
    run_one(0, 32'h8000_0010, 1'b0, 2'd0, 5'd0);
    run_one(2, 32'h0000_6000, 1'b0, 2'd0, 5'd0);
    run_one(2, 32'h0001_0000, 1'b0, 2'd0, 5'd0);
    run_one(2, 32'h0000_0000, 1'b0, 2'd1, 5'd13);
    run_one(2, 32'h0000_0000, 1'b0, 2'd2, 5'd21);

    // All three requesters raise together: cp0, then data, then inst.
    c = cyc;
    cp0_op = 2'd0; cp0_vpn2 = 19'h00002; cp0_req = 1'b1;
    data_vaddr = 32'h0000_4010; data_store = 1'b0; data_req = 1'b1;
    inst_vaddr = 32'h0000_2FFC; inst_req = 1'b1;
    last_probe = 32'h0000_0001; last_mask = '1;
    sb.push_back('{src: 2, val: 32'h0000_0001, mask: '1, exc: 2'd0, cyc: c + 2});
    sb.push_back('{src: 1, val: 32'h0333_3010, mask: '1, exc: 2'd0, cyc: c + 5});
    sb.push_back('{src: 0, val: 32'h0111_1FFC, mask: '1, exc: 2'd0, cyc: c + 8});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      d_cp = cp0_ok; d_d = data_ok; d_i = inst_ok;
      @(posedge clk); #1;
      if (d_cp) cp0_req = 1'b0;
      if (d_d)  data_req = 1'b0;
      if (d_i)  inst_req = 1'b0;
    end
    check("simul_all_served", sb.size(), 0);
    sb.delete();
    inst_req = 1'b0; data_req = 1'b0; cp0_req = 1'b0;
    @(posedge clk); #1;

    // Wired = 4, then back-to-back TLBWR for 60 cycles.
    cp0_wired = 5'd4; cp0_wired_we = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    cp0_wired_we = 1'b0;
    rnd_phase = 1'b1;
    while (cyc < t0 + 60) run_one(2, 32'h0, 1'b0, 2'd3, 5'd0);
    rnd_phase = 1'b0;

    // Reset in the BUSY cycle of a TLBWI abandons it.
    cp0_op = 2'd2; cp0_index = 5'd9; cp0_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_wen_busy", {31'b0, tlb_wen}, 1);
    #1 resetn = 1'b0;
    #1;
    check("abort_wen", {31'b0, tlb_wen}, 0);
    check("abort_ok", {29'b0, inst_ok, data_ok, cp0_ok}, 0);
    check("abort_tlb_vaddr", tlb_vaddr, 0);
    check("abort_random", {27'b0, cp0_random}, 31);
    cp0_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    check("release_random", {27'b0, cp0_random}, 31);
    last_probe = '0; last_mask = '1;
    repeat (4) @(posedge clk);
    #1;
    run_one(1, 32'h0000_4020, 1'b0, 2'd0, 5'd0);

    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_one(kind, pick_va(), 1'($urandom), 2'($urandom_range(0, 1)), 5'($urandom));
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
